// File: rtl/rr_lock_arbiter_if.sv
// Requester-side bundle for rr_lock_arbiter: request/last in, registered grant out.
// The arbiter connects through the slave modport; the requester side uses master.
interface rr_lock_arbiter_if #(
    parameter int NumRequests = 4
);
    localparam int IdW = ($clog2(NumRequests) == 0) ? 1 : $clog2(NumRequests);

    logic [NumRequests-1:0] request;
    logic                   last;
    logic [NumRequests-1:0] grant;
    logic [IdW-1:0]         grant_id;
    logic                   busy;

    modport master (
        output request,
        output last,
        input  grant,
        input  grant_id,
        input  busy
    );

    modport slave (
        input  request,
        input  last,
        output grant,
        output grant_id,
        output busy
    );
endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking: a winner holds the resource until last,
// request drop or MaxHold cycles, then priority moves to the index after it.
module rr_lock_arbiter #(
    parameter int NumRequests = 4,
    parameter int MaxHold     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_lock_arbiter_if.slave bus
);
    localparam int IdW = ($clog2(NumRequests) == 0) ? 1 : $clog2(NumRequests);
    localparam int HcW = $clog2(MaxHold + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state;
    logic [NumRequests-1:0] grant_q;
    logic [IdW-1:0]         id_q;
    logic                   busy_q;
    logic [IdW-1:0]         ptr;
    logic [HcW-1:0]         hcnt;

    logic [IdW-1:0]         nxt_ptr;
    logic [IdW-1:0]         start;
    logic [IdW-1:0]         win_id;
    logic                   win_ok;
    logic                   done;

    // Explicit modulo-NumRequests step so non-power-of-2 sizes wrap correctly.
    function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NumRequests) s = s - NumRequests;
        return IdW'(s);
    endfunction

    assign nxt_ptr = (id_q == IdW'(NumRequests - 1)) ? '0 : id_q + IdW'(1);

    assign done = (state == GRANT) &&
                  (bus.last || !bus.request[id_q] || (hcnt == HcW'(MaxHold)));

    // On termination the scan starts after the finishing holder, same cycle.
    assign start = (state == GRANT) ? nxt_ptr : ptr;

    // Scan farthest offset first so the nearest requester overwrites.
    always_comb begin
        win_ok = 1'b0;
        win_id = '0;
        for (int k = NumRequests - 1; k >= 0; k--) begin
            if (bus.request[wrap_add(start, k)]) begin
                win_ok = 1'b1;
                win_id = wrap_add(start, k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            ptr     <= '0;
            hcnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_ok) begin
                        state   <= GRANT;
                        grant_q <= NumRequests'(1) << win_id;
                        id_q    <= win_id;
                        busy_q  <= 1'b1;
                        hcnt    <= HcW'(1);
                    end
                end
                GRANT: begin
                    if (!done) begin
                        hcnt <= hcnt + HcW'(1);
                    end else begin
                        ptr <= nxt_ptr;
                        if (win_ok) begin
                            grant_q <= NumRequests'(1) << win_id;
                            id_q    <= win_id;
                            busy_q  <= 1'b1;
                            hcnt    <= HcW'(1);
                        end else begin
                            state   <= IDLE;
                            grant_q <= '0;
                            id_q    <= '0;
                            busy_q  <= 1'b0;
                            hcnt    <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = id_q;
    assign bus.busy     = busy_q;

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_busy:   assert property (@(posedge clk) disable iff (!rst_n) busy_q == (grant_q != '0));
    a_id:     assert property (@(posedge clk) disable iff (!rst_n) !busy_q || grant_q[id_q]);
    a_hold:   assert property (@(posedge clk) disable iff (!rst_n) hcnt <= HcW'(MaxHold));
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench: the driver pushes model-predicted outputs, a monitor pops and
// compares them one edge later; directed plan scenarios followed by random traffic.
module tb_rr_lock_arbiter;
    localparam int N  = 4;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_lock_arbiter_if #(.NumRequests(N)) bus();

    rr_lock_arbiter #(.NumRequests(N), .MaxHold(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0] g;
        logic [1:0]   id;
        logic         b;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: who holds, for how long, and where priority starts.
    bit m_busy;
    int m_hold;
    int m_ptr;
    int m_cnt;

    function automatic void model_reset();
        m_busy = 1'b0;
        m_hold = 0;
        m_ptr  = 0;
        m_cnt  = 0;
    endfunction

    function automatic exp_t model_step(input logic [N-1:0] r, input logic l);
        exp_t e;
        bit   arb;
        arb = 1'b1;
        if (m_busy) begin
            if (l || !r[m_hold] || m_cnt == MH) begin
                m_ptr = (m_hold + 1) % N;
            end else begin
                m_cnt = m_cnt + 1;
                arb   = 1'b0;
            end
        end
        if (arb) begin
            m_busy = 1'b0;
            m_hold = 0;
            m_cnt  = 0;
            for (int k = 0; k < N; k++) begin
                if (!m_busy && r[(m_ptr + k) % N]) begin
                    m_busy = 1'b1;
                    m_hold = (m_ptr + k) % N;
                    m_cnt  = 1;
                end
            end
        end
        e.g = '0;
        if (m_busy) e.g[m_hold] = 1'b1;
        e.id = 2'(m_hold);
        e.b  = m_busy;
        return e;
    endfunction

    // Monitor: compares whatever the driver predicted for the edge just taken.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (bus.grant !== e.g || bus.grant_id !== e.id || bus.busy !== e.b) begin
                    errors++;
                    $display("FAIL grant/id/busy at %0t: got %b/%0d/%b expected %b/%0d/%b",
                             $time, bus.grant, bus.grant_id, bus.busy, e.g, e.id, e.b);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (bus.grant !== '0 || bus.grant_id !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got %b/%0d/%b expected 0000/0/0",
                     name, bus.grant, bus.grant_id, bus.busy);
        end
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic l);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.request = r;
        bus.last    = l;
        q.push_back(model_step(r, l));
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        bus.request = 4'b1111;
        bus.last    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset_hold");
    endtask

    task automatic async_reset(input string name);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero(name);
        model_reset();
    endtask

    initial begin
        logic [N-1:0] r;
        logic         l;
        bus.request = 4'b1111;
        bus.last    = 1'b0;
        model_reset();

        // Reset with all requesting, then first grant after release.
        hold_reset();
        cyc(4'b0101, 1'b0);
        cyc(4'b0101, 1'b0);

        // Rotation driven by last.
        hold_reset();
        repeat (6) cyc(4'b1111, 1'b1);

        // Timeout between two requesters, then a lone requester.
        hold_reset();
        repeat (14) cyc(4'b0011, 1'b0);
        hold_reset();
        repeat (10) cyc(4'b0001, 1'b0);

        // Holder 2 drops mid-grant, wrap to 0, idle, then pointer at 3 is visible.
        hold_reset();
        cyc(4'b0100, 1'b0);
        cyc(4'b0100, 1'b0);
        cyc(4'b0001, 1'b0);
        cyc(4'b0000, 1'b1);
        cyc(4'b1001, 1'b0);
        cyc(4'b1001, 1'b1);

        // last while idle, non-holder noise during a grant to index 1.
        hold_reset();
        repeat (3) cyc(4'b0000, 1'b1);
        cyc(4'b0010, 1'b0);
        cyc(4'b1011, 1'b0);
        cyc(4'b0011, 1'b0);
        cyc(4'b1010, 1'b0);
        cyc(4'b1011, 1'b0);
        cyc(4'b1001, 1'b0);

        // Asynchronous reset in the middle of a grant to index 3.
        hold_reset();
        cyc(4'b1000, 1'b0);
        cyc(4'b1000, 1'b0);
        async_reset("async_mid_grant");
        cyc(4'b1001, 1'b0);
        cyc(4'b1001, 1'b0);

        // Random traffic, holder usually keeps requesting, occasional async reset.
        for (int i = 0; i < 800; i++) begin
            r = 4'($urandom_range(0, 15));
            l = ($urandom_range(0, 4) == 0);
            if (m_busy && $urandom_range(0, 3) != 0) r[m_hold] = 1'b1;
            cyc(r, l);
            if (i % 200 == 199) async_reset("async_random");
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_lock_arbiter.md
# rr_lock_arbiter

Round-robin arbiter with grant locking, for sharing one resource among `NumRequests` requesters that need it for multi-cycle bursts. A requester that wins keeps the grant until it signals `last`, drops its request, or hits the `MaxHold` cycle limit. Priority then rotates to the index after the finishing holder. The arbiter sits between the requester ports and the shared resource's select/mux, and drives a registered one-hot grant plus an encoded index.

## Interface
- `NumRequests`, default 4: number of requesters; must be ≥ 2.
- `MaxHold`, default 4: maximum consecutive cycles one grant may be held; must be ≥ 1.
- `IdW`, derived, not overridable: `$clog2(NumRequests)`, or 1 if that is 0.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `request`  in  NumRequests: per-requester request level.
- `last`  in  1: asserted by the current holder in its final grant cycle; ignored when `busy`=0.
- `grant`  out  NumRequests: registered one-hot grant, or all-zero.
- `grant_id`  out  IdW: index of the set `grant` bit; 0 when idle.
- `busy`  out  1: high when `grant` is non-zero.

## Operation
- **State:**
  - FSM with two states, IDLE and GRANT.
  - Priority pointer `ptr` of IdW bits, the highest-priority index.
  - Hold counter `hcnt` of width `$clog2(MaxHold+1)`.
- **Arbitration function:** scan indices `ptr`, `ptr+1`, … with wrap modulo `NumRequests`. The first index with `request` set wins. Wrap arithmetic is explicit: index `NumRequests-1` is followed by 0, so non-power-of-2 sizes are correct.
- **IDLE:**
  - If any `request` bit is set, register the winner into `grant`/`grant_id`, set `busy`, set `hcnt`=1, and go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- **GRANT, termination condition `end`:** any of
  - `last`=1;
  - `request[grant_id]`=0;
  - `hcnt`==`MaxHold`.
- **GRANT, no `end`:** grant is held and `hcnt` increments. `hcnt` never exceeds `MaxHold`.
- **GRANT, on `end`:**
  - `ptr` ← `grant_id+1` with wrap.
  - The arbitration function is evaluated with that new pointer on the same cycle's `request`. The holder is included only if it is still requesting.
  - If there is a winner, load it into `grant`/`grant_id` with `hcnt`=1 and stay in GRANT. This is back-to-back, with no bubble.
  - Otherwise clear outputs and go to IDLE.
- `ptr` changes only on `end`. It is not changed by an IDLE→GRANT transition.
- A holder that is still requesting after a timeout can win again only if no other index requests. A lone requester is therefore re-granted immediately.
- `request` bits of non-holders never disturb an active grant.
- `last` asserted while idle has no effect.

## Timing
- Latency: `request` rises in cycle t (IDLE) → `grant` is valid from cycle t+1.
- Termination: if `end` holds in cycle t, the next grant (or zero) appears in cycle t+1. The old holder sees its final grant cycle in t.
- Maximum continuous grant to one holder while others request: `MaxHold` cycles.
- Worst-case wait for a continuously requesting index: `(NumRequests-1)*MaxHold` cycles after the current grant ends.
- Reset values, applied immediately on `rst_n` low, asynchronously, including mid-grant:
  - `grant`=0, `grant_id`=0, `busy`=0;
  - `ptr`=0, `hcnt`=0, FSM=IDLE.
- Reset release: the first arbitration occurs on the first rising edge with `rst_n`=1.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use `NumRequests`=4 and `MaxHold`=4.
1. **Reset and first grant:** hold `rst_n`=0 with `request`=4'b1111 → all outputs 0. Release reset with `request`=4'b0101 → `grant`=0001, `grant_id`=0, `busy`=1 on the next cycle.
2. **Rotation with `last`:** `request`=4'b1111 held, `last`=1 every cycle → `grant` sequence 0001, 0010, 0100, 1000, 0001, one cycle each, with no bubbles.
3. **Timeout:** `request`=4'b0011, `last`=0 → `grant`=0001 for exactly 4 cycles, then 0010 for 4, then 0001. With `request`=4'b0001 alone → 0001 continuously; `hcnt` restarts every 4 cycles with no zero cycle.
4. **Request drop and wrap:**
   - Holder 2 deasserts `request[2]` in its 2nd cycle while `request`=4'b0001 → next cycle `grant`=0001, `ptr`=3.
   - Then `request`=4'b0000 with `last`=1 → outputs 0, FSM=IDLE.
5. **Idle noise and non-holder requests:**
   - `last`=1 while idle → no change.
   - During a grant to index 1, toggling `request[0]`/`request[3]` → `grant` stays 0010 until `end`.
   - After that `end`, index 3 beats index 0 because the pointer is 2.
6. **Async reset mid-grant:** assert `rst_n`=0 between edges during a grant to index 3 → outputs clear before the next edge. After release with `request`=4'b1001 → `grant`=0001 (`ptr` reset to 0).
